uart_rx_frame_check: RTL

Parametrised frame checker for the UART receiver: replaces the single stop-bit check with a full post-start-bit frame engine. Consumes one mid-bit sample per bit from the data sampler and assembles LSB-first data of configurable width. Checks optional even/odd parity and one or two stop bits, then emits a one-cycle `data_valid` pulse qualified by error flags. Sits between the RX edge/bit counter + sampler and the RX output register; the start check drives `frame_start`.

---
 rtl/uart_rx_pkg.sv | 19 +
 rtl/uart_rx_err_counter.sv | 20 ++
 rtl/uart_rx_frame_check.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive frame checker.
package uart_rx_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } rx_state_t;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   localparam int DATA_WIDTH_MIN = 5;
   localparam int DATA_WIDTH_MAX = 9;
   localparam int STOP_BITS_MIN  = 1;
   localparam int STOP_BITS_MAX  = 2;

endpackage

// File: rtl/uart_rx_err_counter.sv
// Saturating error counter with synchronous clear; clear beats increment.
module uart_rx_err_counter #(
   parameter int CNT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 inc,
   input  logic                 clr,
   output logic [CNT_WIDTH-1:0] count
);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/uart_rx_frame_check.sv
// UART receive frame engine: data/parity/stop assembly and checking after the start bit.
// Error counters are built only when UART_RX_ERR_CNT_EN is defined.
//
//   state  | meaning
//   IDLE   | waiting for frame_start
//   DATA   | shifting in DATA_WIDTH data bits, LSB first
//   PARITY | sampling the parity bit (only when par_en was latched)
//   STOP   | checking STOP_BITS stop bits, then completing the frame
module uart_rx_frame_check
   import uart_rx_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int STOP_BITS  = 1,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  frame_start,
   input  logic                  bit_valid,
   input  logic                  sampled_bit,
   input  logic                  par_en,
   input  logic                  par_typ,
   input  logic                  err_cnt_clr,
   output logic                  busy,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_valid,
   output logic                  par_err,
   output logic                  stop_err,
   output logic [CNT_WIDTH-1:0]  frame_err_cnt,
   output logic [CNT_WIDTH-1:0]  par_err_cnt
);

   if ((DATA_WIDTH < DATA_WIDTH_MIN) || (DATA_WIDTH > DATA_WIDTH_MAX) ||
       (STOP_BITS < STOP_BITS_MIN) || (STOP_BITS > STOP_BITS_MAX)) begin : g_bad_cfg
      $error("uart_rx_frame_check: DATA_WIDTH or STOP_BITS out of range");
   end

   localparam int BCW = 4;

   rx_state_t             state;
   logic [DATA_WIDTH-1:0] shift_reg;
   logic [BCW-1:0]        bit_cnt;
   logic                  par_en_q;
   logic                  par_typ_q;
   logic                  par_acc;
   logic                  stop_acc;

   logic last_stop;
   logic stop_hit;
   logic par_hit;

   // frame_start outranks bit_valid, so a resync on the last stop bit never completes
   assign last_stop = (state == STOP) && bit_valid && !frame_start && (bit_cnt == '0);
   assign stop_hit  = stop_acc | ~sampled_bit;
   assign par_hit   = par_en_q & par_acc;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         shift_reg  <= '0;
         bit_cnt    <= '0;
         par_en_q   <= 1'b0;
         par_typ_q  <= PAR_EVEN;
         par_acc    <= 1'b0;
         stop_acc   <= 1'b0;
         data_out   <= '0;
         data_valid <= 1'b0;
         par_err    <= 1'b0;
         stop_err   <= 1'b0;
         busy       <= 1'b0;
      end else begin
         data_valid <= 1'b0;
         if (frame_start) begin
            state     <= DATA;
            shift_reg <= '0;
            bit_cnt   <= BCW'(DATA_WIDTH - 1);
            par_en_q  <= par_en;
            par_typ_q <= par_typ;
            par_acc   <= 1'b0;
            stop_acc  <= 1'b0;
            busy      <= 1'b1;
         end else if (bit_valid) begin
            case (state)
               IDLE: ;
               DATA: begin
                  shift_reg <= {sampled_bit, shift_reg[DATA_WIDTH-1:1]};
                  if (bit_cnt == '0) begin
                     if (par_en_q) begin
                        state <= PARITY;
                     end else begin
                        state   <= STOP;
                        bit_cnt <= BCW'(STOP_BITS - 1);
                     end
                  end else begin
                     bit_cnt <= bit_cnt - 1'b1;
                  end
               end
               PARITY: begin
                  par_acc <= (^shift_reg) ^ sampled_bit ^ (par_typ_q == PAR_ODD);
                  state   <= STOP;
                  bit_cnt <= BCW'(STOP_BITS - 1);
               end
               STOP: begin
                  stop_acc <= stop_hit;
                  if (bit_cnt == '0) begin
                     state      <= IDLE;
                     busy       <= 1'b0;
                     data_valid <= 1'b1;
                     data_out   <= shift_reg;
                     par_err    <= par_hit;
                     stop_err   <= stop_hit;
                  end else begin
                     bit_cnt <= bit_cnt - 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

`ifdef UART_RX_ERR_CNT_EN
   uart_rx_err_counter #(.CNT_WIDTH(CNT_WIDTH)) u_frame_err_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (last_stop & stop_hit),
      .clr   (err_cnt_clr),
      .count (frame_err_cnt)
   );

   uart_rx_err_counter #(.CNT_WIDTH(CNT_WIDTH)) u_par_err_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (last_stop & par_hit),
      .clr   (err_cnt_clr),
      .count (par_err_cnt)
   );
`else
   logic unused_err_cnt_clr;
   assign unused_err_cnt_clr = err_cnt_clr;
   assign frame_err_cnt      = '0;
   assign par_err_cnt        = '0;
`endif

endmodule
